// File: rtl/popcount_window_accum_pkg.sv
// popacc_pkg: shared types and helpers for popcount_window_accum.
//   popacc_state_e   - accumulator FSM states (IDLE, ACCUM, HOLD)
//   POPACC_MAX_CNT   - default largest legal popcount value
//   popacc_clog2     - ceil(log2(v)) for parameter arithmetic
//   popacc_sum_w_ok  - elaboration-time check that SUM_W cannot overflow
package popacc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } popacc_state_e;

    localparam int unsigned POPACC_MAX_CNT = 32;

    function automatic int unsigned popacc_clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // The sum of WINDOW counts of at most 2**CNT_W-1 each must fit in SUM_W.
    function automatic bit popacc_sum_w_ok(input int unsigned cnt_w,
                                           input int unsigned window,
                                           input int unsigned sum_w);
        return sum_w >= cnt_w + popacc_clog2(window);
    endfunction

endpackage

// File: rtl/popcount_window_accum_if.sv
// popacc_if: count-in / sum-out handshake bundle of popcount_window_accum.
//   cnt_i, cnt_valid_i, cnt_ready_o      - input count stream (valid/ready)
//   sum_o, above_o, sum_valid_o, sum_ready_i - window result stream (valid/ready)
// Modports: slave = accumulator side, master = producer/consumer side.
interface popacc_if #(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned SUM_W = 10
);
    logic [CNT_W-1:0] cnt_i;
    logic             cnt_valid_i;
    logic             cnt_ready_o;
    logic [SUM_W-1:0] sum_o;
    logic             sum_valid_o;
    logic             sum_ready_i;
    logic             above_o;

    modport slave (
        input  cnt_i, cnt_valid_i, sum_ready_i,
        output cnt_ready_o, sum_o, sum_valid_o, above_o
    );

    modport master (
        output cnt_i, cnt_valid_i, sum_ready_i,
        input  cnt_ready_o, sum_o, sum_valid_o, above_o
    );
endinterface

// File: rtl/popcount_window_accum_clamp.sv
// popacc_clamp: combinational saturation of an incoming popcount word.
//   cnt_i  - raw count word
//   cnt_o  - min(cnt_i, MAX_CNT)
//   over_o - high when cnt_i exceeded MAX_CNT (error pulse, not sticky)
module popacc_clamp
    import popacc_pkg::*;
#(
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned MAX_CNT = POPACC_MAX_CNT
) (
    input  logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             over_o
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNT);

    assign over_o = (cnt_i > MAX_C);
    assign cnt_o  = over_o ? MAX_C : cnt_i;
endmodule

// File: rtl/popcount_window_accum.sv
// popcount_window_accum: sums WINDOW consecutive popcount words and presents
// the window sum with a threshold flag on a valid/ready output.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   bus         - popacc_if.slave: cnt_i/cnt_valid_i/cnt_ready_o in,
//                 sum_o/above_o/sum_valid_o/sum_ready_i out
//   clear_i     - synchronous abort of the current window (highest priority)
//   thresh_i    - threshold, sampled on the cycle the window completes
//   err_o       - sticky: a count above MAX_CNT was accepted
//   peak_o      - largest clamped count of the last window
//                 (only when POPACC_PEAK_TRACK_EN is defined)
//
// State | Meaning
// IDLE  | waiting for the first sample of a window
// ACCUM | samples 1..WINDOW-1 accepted, summing
// HOLD  | window sum presented, input stalled until output handshake
module popcount_window_accum
    import popacc_pkg::*;
#(
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned WINDOW  = 16,
    parameter int unsigned SUM_W   = 10,
    parameter int unsigned MAX_CNT = POPACC_MAX_CNT
) (
    input  logic             clk,
    input  logic             rst_n,
    popacc_if.slave          bus,
    input  logic             clear_i,
    input  logic [SUM_W-1:0] thresh_i,
`ifdef POPACC_PEAK_TRACK_EN
    output logic [CNT_W-1:0] peak_o,
`endif
    output logic             err_o
);
    localparam int unsigned N_W = popacc_clog2(WINDOW) + 1;
    localparam logic [N_W-1:0] LAST_N = N_W'(WINDOW - 1);

    if (!popacc_sum_w_ok(CNT_W, WINDOW, SUM_W)) begin : g_sum_w_check
        $error("popcount_window_accum: SUM_W too narrow for CNT_W and WINDOW");
    end

    if (WINDOW < 2) begin : g_window_check
        $error("popcount_window_accum: WINDOW must be at least 2");
    end

    popacc_state_e    state_q;
    logic [SUM_W-1:0] acc_q;
    logic [N_W-1:0]   n_q;
    logic [SUM_W-1:0] sum_q;
    logic             sum_valid_q;
    logic             above_q;
    logic             err_q;
    logic             ready_q;

    logic [CNT_W-1:0] cnt_clamped;
    logic             cnt_over;
    logic [SUM_W-1:0] acc_d;
    logic             above_d;
    logic             in_xfer;
    logic             out_xfer;

    popacc_clamp #(
        .CNT_W   (CNT_W),
        .MAX_CNT (MAX_CNT)
    ) u_clamp (
        .cnt_i  (bus.cnt_i),
        .cnt_o  (cnt_clamped),
        .over_o (cnt_over)
    );

    assign in_xfer  = bus.cnt_valid_i & ready_q;
    assign out_xfer = sum_valid_q & bus.sum_ready_i;
    assign acc_d    = acc_q + {{(SUM_W-CNT_W){1'b0}}, cnt_clamped};
    // Threshold compare includes the final sample of the window.
    assign above_d  = (acc_d >= thresh_i);

`ifdef POPACC_PEAK_TRACK_EN
    logic [CNT_W-1:0] peak_acc_q;
    logic [CNT_W-1:0] peak_acc_d;
    logic [CNT_W-1:0] peak_q;

    assign peak_acc_d = (cnt_clamped > peak_acc_q) ? cnt_clamped : peak_acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            peak_acc_q <= '0;
            peak_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_xfer) peak_acc_q <= cnt_clamped;
                end
                ACCUM: begin
                    if (in_xfer) begin
                        peak_acc_q <= peak_acc_d;
                        if (n_q == LAST_N) peak_q <= peak_acc_d;
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        peak_acc_q <= '0;
                        peak_q     <= '0;
                    end
                end
                default: begin
                    peak_acc_q <= '0;
                    peak_q     <= '0;
                end
            endcase
        end
    end

    assign peak_o = peak_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            n_q         <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            above_q     <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else if (clear_i) begin
            // Abort wins over any transfer on either side this cycle.
            state_q     <= IDLE;
            acc_q       <= '0;
            n_q         <= '0;
            sum_valid_q <= 1'b0;
            above_q     <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            if (in_xfer && cnt_over) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (in_xfer) begin
                        acc_q   <= {{(SUM_W-CNT_W){1'b0}}, cnt_clamped};
                        n_q     <= N_W'(1);
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_xfer) begin
                        acc_q <= acc_d;
                        n_q   <= n_q + N_W'(1);
                        if (n_q == LAST_N) begin
                            sum_q       <= acc_d;
                            above_q     <= above_d;
                            sum_valid_q <= 1'b1;
                            ready_q     <= 1'b0;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        sum_valid_q <= 1'b0;
                        acc_q       <= '0;
                        n_q         <= '0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt_ready_o = ready_q;
    assign bus.sum_o       = sum_q;
    assign bus.sum_valid_o = sum_valid_q;
    assign bus.above_o     = above_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_popcount_window_accum.sv
module tb_popcount_window_accum;
    logic       clk;
    logic       rst_n;
    logic       clear_i;
    logic [9:0] thresh_i;
    logic       err_o;
`ifdef POPACC_PEAK_TRACK_EN
    logic [5:0] peak_o;
`endif
    int checks;
    int errors;

    popacc_if #(.CNT_W(6), .SUM_W(10)) bus ();

    popcount_window_accum #(
        .CNT_W(6), .WINDOW(16), .SUM_W(10), .MAX_CNT(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clear_i  (clear_i),
        .thresh_i (thresh_i),
`ifdef POPACC_PEAK_TRACK_EN
        .peak_o   (peak_o),
`endif
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.cnt_i       = v;
            bus.cnt_valid_i = 1'b1;
            step();
        end
        bus.cnt_valid_i = 1'b0;
    endtask

    task automatic handshake();
        bus.sum_ready_i = 1'b1;
        step();
        bus.sum_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.cnt_ready_o !== 1'b0 || bus.sum_valid_o !== 1'b0 || bus.sum_o !== 10'd0 ||
            bus.above_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b sum=%0d above=%b err=%b, want 0 0 0 0 0",
                     bus.cnt_ready_o, bus.sum_valid_o, bus.sum_o, bus.above_o, err_o);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.cnt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", bus.cnt_ready_o);
        end
    endtask

    task automatic test_full_window();
        thresh_i = 10'd300;
        send(6'd20, 15);
        checks++;
        if (bus.sum_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_early_valid: got %b want 0", bus.sum_valid_o);
        end
        send(6'd20, 1);
        checks++;
        if (bus.sum_valid_o !== 1'b1 || bus.sum_o !== 10'd320 || bus.above_o !== 1'b1 ||
            err_o !== 1'b0 || bus.cnt_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_result: valid=%b sum=%0d above=%b err=%b ready=%b, want 1 320 1 0 0",
                     bus.sum_valid_o, bus.sum_o, bus.above_o, err_o, bus.cnt_ready_o);
        end
        handshake();
        checks++;
        if (bus.sum_valid_o !== 1'b0 || bus.cnt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_after_hs: valid=%b ready=%b, want 0 1",
                     bus.sum_valid_o, bus.cnt_ready_o);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        thresh_i = 10'd300;
        send(6'd5, 16);
        // Upstream keeps offering data while the result is held.
        bus.cnt_i       = 6'd7;
        bus.cnt_valid_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.sum_valid_o !== 1'b1 || bus.sum_o !== 10'd80 || bus.above_o !== 1'b0 ||
                bus.cnt_ready_o !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 3)
                    $display("FAIL bp_hold[%0d]: valid=%b sum=%0d above=%b ready=%b, want 1 80 0 0",
                             i, bus.sum_valid_o, bus.sum_o, bus.above_o, bus.cnt_ready_o);
            end
            step();
        end
        bus.cnt_valid_i = 1'b0;
        handshake();
        checks++;
        if (bus.sum_valid_o !== 1'b0 || bus.cnt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_hs: valid=%b ready=%b, want 0 1",
                     bus.sum_valid_o, bus.cnt_ready_o);
        end
    endtask

    task automatic test_clamp();
        thresh_i = 10'd300;
        send(6'd45, 1);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL clamp_err_set: got %b want 1", err_o);
        end
        send(6'd0, 15);
        checks++;
        if (bus.sum_valid_o !== 1'b1 || bus.sum_o !== 10'd32 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL clamp_sum: valid=%b sum=%0d err=%b, want 1 32 1",
                     bus.sum_valid_o, bus.sum_o, err_o);
        end
        handshake();
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL clamp_err_sticky: got %b want 1", err_o);
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL clamp_err_clear: got %b want 0", err_o);
        end
    endtask

    task automatic test_abort();
        send(6'd32, 7);
        clear_i         = 1'b1;
        bus.cnt_i       = 6'd32;
        bus.cnt_valid_i = 1'b1;
        step();
        clear_i         = 1'b0;
        bus.cnt_valid_i = 1'b0;
        checks++;
        if (bus.sum_valid_o !== 1'b0 || bus.cnt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: valid=%b ready=%b, want 0 1",
                     bus.sum_valid_o, bus.cnt_ready_o);
        end
        thresh_i = 10'd16;
        send(6'd1, 16);
        checks++;
        if (bus.sum_valid_o !== 1'b1 || bus.sum_o !== 10'd16 || bus.above_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_sum: valid=%b sum=%0d above=%b, want 1 16 1",
                     bus.sum_valid_o, bus.sum_o, bus.above_o);
        end
        handshake();
        // Clear while a result is pending and the consumer is ready: result dropped.
        thresh_i = 10'd10;
        send(6'd2, 16);
        clear_i         = 1'b1;
        bus.sum_ready_i = 1'b1;
        step();
        clear_i         = 1'b0;
        bus.sum_ready_i = 1'b0;
        checks++;
        if (bus.sum_valid_o !== 1'b0 || bus.above_o !== 1'b0 || bus.cnt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold_drop: valid=%b above=%b ready=%b, want 0 0 1",
                     bus.sum_valid_o, bus.above_o, bus.cnt_ready_o);
        end
    endtask

    task automatic test_mid_reset();
        thresh_i = 10'd513;
        send(6'd32, 9);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.sum_valid_o !== 1'b0 || bus.cnt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_state: valid=%b ready=%b, want 0 1",
                     bus.sum_valid_o, bus.cnt_ready_o);
        end
        send(6'd32, 15);
        thresh_i = 10'd512;
        send(6'd32, 1);
        checks++;
        if (bus.sum_valid_o !== 1'b1 || bus.sum_o !== 10'd512 || bus.above_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_sum: valid=%b sum=%0d above=%b, want 1 512 1",
                     bus.sum_valid_o, bus.sum_o, bus.above_o);
        end
        handshake();
        thresh_i = 10'd513;
        send(6'd32, 16);
        checks++;
        if (bus.sum_o !== 10'd512 || bus.above_o !== 1'b0) begin
            errors++;
            $display("FAIL thresh_above_max: sum=%0d above=%b, want 512 0",
                     bus.sum_o, bus.above_o);
        end
        handshake();
    endtask

`ifdef POPACC_PEAK_TRACK_EN
    task automatic test_peak();
        for (int i = 0; i < 8; i++) begin
            send(6'd3, 1);
            send(6'd31, 1);
        end
        checks++;
        if (bus.sum_valid_o !== 1'b1 || bus.sum_o !== 10'd272 || peak_o !== 6'd31) begin
            errors++;
            $display("FAIL peak_value: valid=%b sum=%0d peak=%0d, want 1 272 31",
                     bus.sum_valid_o, bus.sum_o, peak_o);
        end
        handshake();
        checks++;
        if (peak_o !== 6'd0) begin
            errors++;
            $display("FAIL peak_cleared: got %0d want 0", peak_o);
        end
    endtask
`endif

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        clear_i         = 1'b0;
        thresh_i        = '0;
        bus.cnt_i       = '0;
        bus.cnt_valid_i = 1'b0;
        bus.sum_ready_i = 1'b0;
        test_reset();
        test_full_window();
        test_backpressure();
        test_clamp();
        test_abort();
        test_mid_reset();
`ifdef POPACC_PEAK_TRACK_EN
        test_peak();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/popcount_window_accum.md
Name: popcount_window_accum

Overview:
- Downstream consumer of the 32-input population-count stage.
- Accepts one 6-bit count word (range 0..32) per handshake and sums WINDOW consecutive counts.
- Presents the window sum plus a threshold flag on a valid/ready output.
- Feeds density and threshold decisions in the next pipeline stage.

Parameters:
CNT_W, 6, width of the incoming count word; legal values 0..32
WINDOW, 16, number of count samples per window; must be >= 2
SUM_W, 10, accumulator and sum width; must satisfy SUM_W >= CNT_W + clog2(WINDOW)
MAX_CNT, 32, largest legal input count; larger values are clamped

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
cnt_i  input  CNT_W  count word from the popcount stage
cnt_valid_i  input  1  cnt_i is valid
cnt_ready_o  output  1  block accepts cnt_i this cycle
clear_i  input  1  synchronous abort of the current window
thresh_i  input  SUM_W  compare threshold; sampled when the window completes
sum_o  output  SUM_W  completed window sum
sum_valid_o  output  1  sum_o and above_o are valid
sum_ready_i  input  1  downstream accepts sum_o
above_o  output  1  sum_o >= sampled thresh_i
err_o  output  1  sticky flag: a count greater than MAX_CNT was received

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, accumulator=0, sample counter=0.
  - sum_o=0, sum_valid_o=0, above_o=0, err_o=0.
  - cnt_ready_o=0 while rst_n=0; cnt_ready_o=1 on the first cycle after reset is released.
- Transfer rules:
  - An input transfer occurs when cnt_valid_i & cnt_ready_o.
  - An output transfer occurs when sum_valid_o & sum_ready_i.
- FSM:
  - IDLE: cnt_ready_o=1. On an input transfer: acc<=clamp(cnt_i), n<=1, go to ACCUM.
  - ACCUM: cnt_ready_o=1. On an input transfer: acc<=acc+clamp(cnt_i), n<=n+1. If that transfer is sample number WINDOW, go to HOLD and register sum_o, above_o (compared against thresh_i of that cycle, including the final sample) and sum_valid_o=1.
  - HOLD: cnt_ready_o=0. sum_o, above_o and sum_valid_o are stable until the output transfer. On the output transfer: sum_valid_o<=0, acc<=0, n<=0, go to IDLE. cnt_ready_o returns to 1 on the next cycle; there is no same-cycle bypass.
- Latency: final sample accepted at edge N; sum_valid_o=1 from edge N onward, i.e. visible in cycle N+1.
- Clamp and error:
  - clamp(x) = MAX_CNT if x > MAX_CNT, else x.
  - Receiving x > MAX_CNT sets err_o, which stays set until clear_i or reset.
- Arithmetic and width:
  - Unsigned, zero-extended to SUM_W.
  - Overflow is impossible given the SUM_W constraint (max 16*32=512 < 1024).
- clear_i (priority above every other event, any state):
  - Next state IDLE, acc=0, n=0, sum_valid_o=0, above_o=0, err_o=0.
  - An input transfer in the same cycle is discarded.
  - A pending sum in HOLD is dropped, even if sum_ready_i=1 in that cycle.
- Simultaneous events: cnt_valid_i=1 while in HOLD is ignored; the upstream stage must hold its data until ready.
- Reset mid-window or mid-HOLD: the partial window is discarded with no output; reset values apply.
- sum_ready_i is don't-care while sum_valid_o=0.

Optional Feature:
- Macro: POPACC_PEAK_TRACK_EN.
- Defined:
  - Adds output peak_o [CNT_W-1:0]: the largest clamped count accepted in the current window.
  - Updated on every input transfer; registered alongside sum_o at window completion.
  - Cleared with acc (on output transfer, clear_i or reset); reset value 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package popacc_pkg holds:
  - state enum (IDLE, ACCUM, HOLD);
  - MAX_CNT default;
  - the clog2 helper;
  - an elaboration-time check of the SUM_W constraint.
- One sub-module: popacc_clamp, combinational; clamps cnt_i and produces the err pulse.
- FSM, accumulator and output register stay in the top module.

Test Plan:
- Full window: reset, then 16 samples of cnt_i=20 with valid held high and thresh_i=300 -> sum_o=320, above_o=1, err_o=0; sum_valid_o rises one cycle after the 16th transfer.
- Backpressure: complete a window of 16x5 (sum 80) with thresh_i=300, hold sum_ready_i=0 for 10 cycles -> sum_o=80, above_o=0, sum_valid_o stable, cnt_ready_o=0 throughout; after the handshake, cnt_ready_o=1 one cycle later.
- Clamp: sample cnt_i=45 followed by 15x0 -> sum_o=32, err_o=1 from the cycle after that sample until clear_i.
- Abort: 7 samples of 32, then clear_i=1 together with cnt_valid_i=1 -> sample discarded; the next 16x1 window yields sum_o=16.
- Mid-window reset: reset after 9 samples -> no sum_valid_o; the next 16x32 window yields sum_o=512.
- Peak (macro on): window of alternating 3/31 values -> peak_o=31; after the output handshake peak_o=0.
